// File: rtl/game_controller_pkg.sv
// Shared definitions for the frog game: state encodings, playfield geometry
// and a small saturating-increment helper.
package game_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  localparam int unsigned CELL         = 32;
  localparam int unsigned FROG_START_X = 320;
  localparam int unsigned FROG_START_Y = 448;
  localparam int unsigned GOAL_Y_DEF   = 0;
  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;

  // Wide enough for a 1 s freeze at 25 MHz.
  localparam int unsigned TIMER_W = 25;

  // Increment that sticks at lim instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? v : v + 1;
  endfunction

endpackage

// File: rtl/game_controller_timer.sv
// Freeze timer: loads a count, decrements to zero and holds there.
module game_controller_timer
  import game_controller_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // Load has priority; otherwise count down until zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/game_controller.sv
// Game sequencer: gates frog movement, pulses the frog reset on every
// (re)entry to play, and keeps lives, level and score.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned HIT_CYCLES = 25000000,
  parameter int unsigned WIN_CYCLES = 12500000,
  parameter int unsigned GOAL_Y     = GOAL_Y_DEF,
  parameter int unsigned MAX_LEVEL  = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       collision,
  input  logic [9:0] frog_y,
  output logic       frog_reset,
  output logic       move_enable,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [7:0] score,
  output logic [2:0] game_state
);

  state_e       state_q, state_d;
  logic [1:0]   lives_q, lives_d;
  logic [3:0]   level_q, level_d;
  logic [7:0]   score_q, score_d;
  logic         frog_reset_q, frog_reset_d;
  logic         move_enable_q, move_enable_d;
  logic         start_prev_q;
  logic         start_edge;
  logic         tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic         tmr_expired;

  assign start_edge = start & ~start_prev_q;

  game_controller_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lives_q       <= 2'(LIVES_INIT);
      level_q       <= '0;
      score_q       <= '0;
      frog_reset_q  <= 1'b0;
      move_enable_q <= 1'b0;
      // Held at 1 so a start switch already high when reset releases is
      // not mistaken for a fresh press; it follows start from the first clock.
      start_prev_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      score_q       <= score_d;
      frog_reset_q  <= frog_reset_d;
      move_enable_q <= move_enable_d;
      start_prev_q  <= start;
    end
  end

  // Next-state, counters and timer control.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    level_d       = level_q;
    score_d       = score_q;
    frog_reset_d  = 1'b0;
    move_enable_d = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d       = ST_PLAY;
          lives_d       = 2'(LIVES_INIT);
          level_d       = '0;
          score_d       = '0;
          frog_reset_d  = 1'b1;
          move_enable_d = 1'b1;
        end
      end
      ST_PLAY: begin
        move_enable_d = 1'b1;
        // Frog position is still settling while its reset pulse is high.
        if (!frog_reset_q) begin
          if (collision) begin
            state_d       = ST_HIT;
            lives_d       = lives_q - 2'd1;
            tmr_load      = 1'b1;
            tmr_val       = TIMER_W'(HIT_CYCLES - 1);
            move_enable_d = 1'b0;
          end else if (frog_y == 10'(GOAL_Y)) begin
            state_d       = ST_WIN;
            tmr_load      = 1'b1;
            tmr_val       = TIMER_W'(WIN_CYCLES - 1);
            move_enable_d = 1'b0;
            score_d       = 8'(sat_inc(32'(score_q), 255));
            level_d       = 4'(sat_inc(32'(level_q), MAX_LEVEL));
          end
        end
      end
      ST_HIT: begin
        if (tmr_expired) begin
          if (lives_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d       = ST_PLAY;
            frog_reset_d  = 1'b1;
            move_enable_d = 1'b1;
          end
        end
      end
      ST_WIN: begin
        if (tmr_expired) begin
          state_d       = ST_PLAY;
          frog_reset_d  = 1'b1;
          move_enable_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frog_reset  = frog_reset_q;
  assign move_enable = move_enable_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign score       = score_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed stimulus, a cycle-level game model
// checked every cycle, and literal expectations at key points.
module tb_game_controller;

  localparam int HITC = 4;
  localparam int WINC = 3;
  localparam int LIV  = 3;
  localparam int MAXL = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       collision;
  logic [9:0] frog_y;
  logic       frog_reset;
  logic       move_enable;
  logic [1:0] lives;
  logic [3:0] level;
  logic [7:0] score;
  logic [2:0] game_state;

  int checks   = 0;
  int failures = 0;

  game_controller #(
    .LIVES_INIT (LIV),
    .HIT_CYCLES (HITC),
    .WIN_CYCLES (WINC),
    .GOAL_Y     (0),
    .MAX_LEVEL  (MAXL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .collision   (collision),
    .frog_y      (frog_y),
    .frog_reset  (frog_reset),
    .move_enable (move_enable),
    .lives       (lives),
    .level       (level),
    .score       (score),
    .game_state  (game_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase numbers are the display codes; a freeze is counted
  // as cycles remaining, and m_fresh marks the first cycle of a play period.
  int m_phase, m_left, m_lives, m_level, m_score;
  bit m_fresh, m_prev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_left = 0; m_lives = LIV; m_level = 0; m_score = 0;
      m_fresh = 0; m_prev = 1;
    end else begin
      bit pressed;
      pressed = start && !m_prev;
      m_prev  = start;
      case (m_phase)
        0, 4: if (pressed) begin
          m_phase = 1; m_lives = LIV; m_level = 0; m_score = 0; m_fresh = 1;
        end
        1: begin
          if (m_fresh) m_fresh = 0;
          else if (collision) begin
            m_lives = m_lives - 1; m_phase = 2; m_left = HITC;
          end else if (frog_y == 0) begin
            m_phase = 3; m_left = WINC;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
          end
        end
        2: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_lives == 0) m_phase = 4;
            else begin m_phase = 1; m_fresh = 1; end
          end
        end
        3: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = 1; m_fresh = 1; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_state", game_state, m_phase);
    chk("m_move_enable", move_enable, (m_phase == 1));
    chk("m_frog_reset", frog_reset, (m_phase == 1) && m_fresh);
    chk("m_lives", lives, m_lives);
    chk("m_level", level, m_level);
    chk("m_score", score, m_score);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goal();
    frog_y = 10'd0;
    step();
    frog_y = 10'd448;
    repeat (WINC) step();
    step();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; collision = 1'b0; frog_y = 10'd448;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step(); step();
    chk("rst_state", game_state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_score", score, 0);
    chk("rst_move", move_enable, 0);
    chk("rst_frog_reset", frog_reset, 0);

    // Start edge enters play with a one-cycle frog reset.
    start = 1'b1; step();
    chk("start_state", game_state, 1);
    chk("start_frog_reset", frog_reset, 1);
    chk("start_move", move_enable, 1);
    chk("start_lives", lives, 3);
    start = 1'b0; step();
    chk("start_fr_low", frog_reset, 0);

    // Single hit: 4-cycle freeze; collisions inside the freeze are ignored.
    collision = 1'b1; step(); collision = 1'b0;
    chk("hit1_state", game_state, 2);
    chk("hit1_lives", lives, 2);
    chk("hit1_move", move_enable, 0);
    collision = 1'b1; step(); collision = 1'b0;
    step(); step();
    chk("hit1_still", game_state, 2);
    chk("hit1_lives_once", lives, 2);
    step();
    chk("hit1_back", game_state, 1);
    chk("hit1_frog_reset", frog_reset, 1);
    step();

    // Second hit; a collision during the settling cycle is ignored.
    collision = 1'b1; step(); collision = 1'b0;
    chk("hit2_lives", lives, 1);
    repeat (HITC) step();
    chk("hit2_fr", frog_reset, 1);
    collision = 1'b1; step(); collision = 1'b0;
    chk("settle_ignore_state", game_state, 1);
    chk("settle_ignore_lives", lives, 1);

    // Last life: start pressed during the freeze and held into game over.
    collision = 1'b1; step(); collision = 1'b0;
    chk("hit3_lives", lives, 0);
    start = 1'b1;
    repeat (HITC) step();
    chk("over_state", game_state, 4);
    chk("over_move", move_enable, 0);
    chk("over_fr", frog_reset, 0);
    repeat (3) step();
    chk("over_held_start", game_state, 4);
    start = 1'b0; step();
    start = 1'b1; step();
    chk("restart_state", game_state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_fr", frog_reset, 1);
    start = 1'b0; step();

    // Goal: 3-cycle freeze, score and level bump.
    frog_y = 10'd0; step();
    chk("win_state", game_state, 3);
    chk("win_score", score, 1);
    chk("win_level", level, 1);
    chk("win_move", move_enable, 0);
    frog_y = 10'd448; step(); step();
    chk("win_still", game_state, 3);
    step();
    chk("win_back", game_state, 1);
    chk("win_fr", frog_reset, 1);
    step();
    for (int i = 0; i < 19; i++) goal();
    chk("sat_level", level, 15);
    chk("sat_score", score, 20);

    // Collision beats goal in the same cycle.
    collision = 1'b1; frog_y = 10'd0; step();
    collision = 1'b0; frog_y = 10'd448;
    chk("prio_state", game_state, 2);
    chk("prio_lives", lives, 2);
    chk("prio_score", score, 20);

    // Asynchronous reset mid-freeze.
    step();
    reset_n = 1'b0; #1;
    chk("arst_state", game_state, 0);
    chk("arst_lives", lives, 3);
    chk("arst_level", level, 0);
    chk("arst_score", score, 0);
    chk("arst_move", move_enable, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    step();

    // Collision during a goal freeze is ignored.
    start = 1'b1; step(); start = 1'b0; step();
    frog_y = 10'd0; step();
    chk("win2_state", game_state, 3);
    frog_y = 10'd448; collision = 1'b1; step(); collision = 1'b0;
    step(); step();
    chk("win2_back", game_state, 1);
    chk("win2_lives", lives, 3);
    chk("win2_score", score, 1);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
